// File: rtl/branch_predictor_btb.sv
// branch_predictor_btb
//
// Dynamic branch predictor that sits beside the IF stage. It combines a
// direct-mapped branch target buffer with a 2-bit saturating direction
// counter per entry. The fetch PC is looked up combinationally every cycle.
// Resolved branches reported by EX train the table on the clock edge. The
// block also flags mispredicts so the core can flush IF/ID and redirect.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   if_pc               PC being fetched
//   pred_taken          lookup result: branch predicted taken
//   pred_target         predicted next PC for if_pc
//   upd_valid           EX reports a resolved branch this cycle
//   upd_pc              PC of the resolved branch
//   upd_taken           actual outcome
//   upd_target          actual taken target
//   upd_pred_taken      prediction that travelled down the pipe with the branch
//   upd_pred_target     predicted next PC that travelled with the branch
//   tbl_clear           synchronous invalidate of the whole table
//   mispredict          redirect required this cycle
//   redirect_pc         correct next PC when mispredict is high
//   mispred_cnt         saturating mispredict statistics counter

module branch_predictor_btb #(
    parameter int PC_W       = 32,
    parameter int INDEX_BITS = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PC_W-1:0]  if_pc,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [PC_W-1:0]  upd_pred_target,
    input  logic             tbl_clear,
    output logic             mispredict,
    output logic [PC_W-1:0]  redirect_pc,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = PC_W - INDEX_BITS - 2;

    logic             valid_q  [ENTRIES];
    logic [1:0]       ctr_q    [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [PC_W-1:0]  target_q [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [PC_W-1:0]  target_d [ENTRIES];
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;

    logic [INDEX_BITS-1:0] if_idx, upd_idx;
    logic [TAG_W-1:0]      if_tag, upd_tag;
    logic                  if_hit, upd_hit;

    // The two low PC bits never take part in indexing or tagging.
    assign if_idx  = if_pc[INDEX_BITS+1:2];
    assign if_tag  = if_pc[PC_W-1:INDEX_BITS+2];
    assign upd_idx = upd_pc[INDEX_BITS+1:2];
    assign upd_tag = upd_pc[PC_W-1:INDEX_BITS+2];

    // Fetch-side lookup reads the registered table, so an update landing on
    // the same entry this cycle only becomes visible on the following cycle.
    assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
    assign pred_taken  = if_hit && ctr_q[if_idx][1];
    assign pred_target = pred_taken ? target_q[if_idx] : if_pc + PC_W'(4);

    // A taken branch with the right direction but the wrong target still
    // needs a redirect.
    assign upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign mispredict  = upd_valid &&
                         ((upd_pred_taken != upd_taken) ||
                          (upd_taken && (upd_pred_target != upd_target)));
    assign redirect_pc = upd_taken ? upd_target : upd_pc + PC_W'(4);
    assign mispred_cnt = mispred_cnt_q;

    // Next-state of the table. A clear discards any update in the same cycle.
    // A miss that is not taken leaves the table alone, so that a not-taken
    // branch does not evict a useful entry.
    always_comb begin
        valid_d  = valid_q;
        ctr_d    = ctr_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (tbl_clear) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_d[i] = 1'b0;
                ctr_d[i]   = 2'b01;
            end
        end else if (upd_valid) begin
            if (upd_hit) begin
                if (upd_taken) begin
                    ctr_d[upd_idx]    = (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'b01;
                    target_d[upd_idx] = upd_target;
                end else begin
                    ctr_d[upd_idx]    = (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
                ctr_d[upd_idx]    = 2'b10;
            end
        end
    end

    // The statistics counter ignores tbl_clear and saturates at all-ones.
    always_comb begin
        mispred_cnt_d = mispred_cnt_q;
        if (mispredict && (mispred_cnt_q != {CNT_W{1'b1}})) begin
            mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
        end
    end

    // State registers. Counters reset to weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_q[i]  <= 1'b0;
                ctr_q[i]    <= 2'b01;
                tag_q[i]    <= '0;
                target_q[i] <= '0;
            end
            mispred_cnt_q <= '0;
        end else begin
            valid_q       <= valid_d;
            ctr_q         <= ctr_d;
            tag_q         <= tag_d;
            target_q      <= target_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
module tb_branch_predictor_btb;

    localparam int NE = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   if_pc;
    logic          pred_taken;
    logic [31:0]   pred_target;
    logic          upd_valid;
    logic [31:0]   upd_pc;
    logic          upd_taken;
    logic [31:0]   upd_target;
    logic          upd_pred_taken;
    logic [31:0]   upd_pred_target;
    logic          tbl_clear;
    logic          mispredict;
    logic [31:0]   redirect_pc;
    logic [CW-1:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: each entry remembers the word address of the branch
    // that owns it, its taken target and a 0..3 confidence count.
    bit          mValid [NE];
    logic [29:0] mWord  [NE];
    int          mCtr   [NE];
    logic [31:0] mTgt   [NE];
    int          mCnt;

    branch_predictor_btb #(.PC_W(32), .INDEX_BITS(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .if_pc(if_pc),
        .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_pred_taken(upd_pred_taken),
        .upd_pred_target(upd_pred_target), .tbl_clear(tbl_clear),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    function automatic int slotOf(logic [31:0] pc);
        return int'((pc >> 2) % NE);
    endfunction

    function automatic bit mHit(logic [31:0] pc);
        return mValid[slotOf(pc)] && (mWord[slotOf(pc)] == pc[31:2]);
    endfunction

    function automatic bit mPredTaken(logic [31:0] pc);
        return mHit(pc) && (mCtr[slotOf(pc)] >= 2);
    endfunction

    function automatic logic [31:0] mPredTarget(logic [31:0] pc);
        return mPredTaken(pc) ? mTgt[slotOf(pc)] : pc + 32'd4;
    endfunction

    task automatic modelReset();
        for (int i = 0; i < NE; i++) begin
            mValid[i] = 0;
            mWord[i]  = '0;
            mCtr[i]   = 1;
            mTgt[i]   = '0;
        end
        mCnt = 0;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock of traffic: drive at the falling edge, check the
    // combinational outputs against the pre-edge model, advance the model at
    // the rising edge, then check the statistics counter.
    task automatic applyStimulus(input logic [31:0] ifPc, input bit uv, input logic [31:0] upc,
                                 input bit ut, input logic [31:0] utgt, input bit upt,
                                 input logic [31:0] uptgt, input bit clr);
        bit expMis;
        int s;
        @(negedge clk);
        if_pc = ifPc; upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
        upd_pred_taken = upt; upd_pred_target = uptgt; tbl_clear = clr;
        #1;
        expMis = uv && ((upt != ut) || (ut && (uptgt != utgt)));
        checkOutput("pred_taken", {31'b0, pred_taken}, {31'b0, mPredTaken(ifPc)});
        checkOutput("pred_target", pred_target, mPredTarget(ifPc));
        checkOutput("mispredict", {31'b0, mispredict}, {31'b0, expMis});
        if (uv) checkOutput("redirect_pc", redirect_pc, ut ? utgt : upc + 32'd4);
        @(posedge clk);
        if (expMis && (mCnt < (1 << CW) - 1)) mCnt++;
        s = slotOf(upc);
        if (clr) begin
            for (int i = 0; i < NE; i++) begin
                mValid[i] = 0;
                mCtr[i]   = 1;
            end
        end else if (uv) begin
            if (mHit(upc)) begin
                if (ut) begin
                    mCtr[s] = (mCtr[s] + 1 > 3) ? 3 : mCtr[s] + 1;
                    mTgt[s] = utgt;
                end else begin
                    mCtr[s] = (mCtr[s] - 1 < 0) ? 0 : mCtr[s] - 1;
                end
            end else if (ut) begin
                mValid[s] = 1;
                mWord[s]  = upc[31:2];
                mTgt[s]   = utgt;
                mCtr[s]   = 2;
            end
        end
        #1;
        checkOutput("mispred_cnt", 32'(mispred_cnt), 32'(mCnt));
    endtask

    task automatic idle(input logic [31:0] ifPc);
        applyStimulus(ifPc, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    initial begin
        logic [31:0] rpc, rtgt, rptgt;
        bit rt, rpt;

        // Reset state
        rst_n = 1'b0; if_pc = 32'h40; upd_valid = 0; upd_pc = 0; upd_taken = 0;
        upd_target = 0; upd_pred_taken = 0; upd_pred_target = 0; tbl_clear = 0;
        modelReset();
        #12;
        checkOutput("reset_pred_taken", {31'b0, pred_taken}, 32'h0);
        checkOutput("reset_pred_target", pred_target, 32'h44);
        checkOutput("reset_cnt", 32'(mispred_cnt), 32'h0);
        rst_n = 1'b1;

        // First taken branch allocates and mispredicts
        applyStimulus(32'h40, 1, 32'h40, 1, 32'h100, 0, 32'h44, 0);
        idle(32'h40);
        checkOutput("alloc_hit_taken", {31'b0, pred_taken}, 32'h1);
        checkOutput("alloc_hit_target", pred_target, 32'h100);

        // Train down to strongly not-taken, then saturate upward
        applyStimulus(32'h40, 1, 32'h40, 0, 32'h100, 1, 32'h100, 0);
        idle(32'h40);
        applyStimulus(32'h40, 1, 32'h40, 0, 32'h100, 0, 32'h44, 0);
        idle(32'h40);
        for (int k = 0; k < 5; k++)
            applyStimulus(32'h40, 1, 32'h40, 1, 32'h100, mPredTaken(32'h40), mPredTarget(32'h40), 0);
        idle(32'h40);

        // Alias: same slot, different tag replaces the entry
        applyStimulus(32'h80, 1, 32'h80, 1, 32'h200, 0, 32'h84, 0);
        idle(32'h40);
        idle(32'h80);
        idle(32'h83);

        // Same-cycle lookup and update on one entry
        applyStimulus(32'h40, 1, 32'h40, 1, 32'h300, 0, 32'h44, 0);
        idle(32'h40);

        // PC increment wraps
        idle(32'hFFFF_FFFC);
        idle(32'hFFFF_FFFE);

        // Random traffic over a few tags so entries hit, alias and clear
        for (int k = 0; k < 300; k++) begin
            rpc   = (32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            rt    = 1'($urandom_range(0, 1));
            rtgt  = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
            if ($urandom_range(0, 1) == 1) begin
                rpt = mPredTaken(rpc); rptgt = mPredTarget(rpc);
            end else begin
                rpt = 1'($urandom_range(0, 1)); rptgt = 32'h1000 + (32'($urandom_range(0, 3)) << 4);
            end
            applyStimulus((32'($urandom_range(0, 3)) << 6) | (32'($urandom_range(0, 15)) << 2),
                          1'($urandom_range(0, 3) != 0), rpc, rt, rtgt, rpt, rptgt,
                          $urandom_range(0, 24) == 0);
        end

        // Clear wins over a concurrent update
        applyStimulus(32'h40, 1, 32'h40, 1, 32'h500, 0, 32'h44, 0);
        applyStimulus(32'h40, 1, 32'h7C, 1, 32'h600, 0, 32'h80, 1);
        idle(32'h40);
        idle(32'h7C);

        // Drive the statistics counter past saturation
        for (int k = 0; k < (1 << CW) + 3; k++)
            applyStimulus(32'h40, 1, 32'h40, 1, 32'h700, 0, 32'h44, 0);
        checkOutput("cnt_saturated", 32'(mispred_cnt), 32'(((1 << CW) - 1)));

        // Asynchronous reset without a clock edge
        @(negedge clk);
        upd_valid = 0; tbl_clear = 0; if_pc = 32'h40;
        #1;
        checkOutput("pre_reset_taken", {31'b0, pred_taken}, {31'b0, mPredTaken(32'h40)});
        #1;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset_taken", {31'b0, pred_taken}, 32'h0);
        checkOutput("async_reset_target", pred_target, 32'h44);
        checkOutput("async_reset_cnt", 32'(mispred_cnt), 32'h0);
        #1;
        rst_n = 1'b1;
        idle(32'h40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
